// File: rtl/timer_counter_bank.sv
// timer_counter_bank: bank of prescaled up-counters with compare-match, overflow and one-shot modes.
// Define TIMER_COUNTER_BANK_IRQ_EN to implement CTRL.irq_en and drive irq; otherwise irq is tied low.
module timer_counter_bank #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int AW       = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    rd_data,
    output logic [CHANNELS-1:0] irq
);
    localparam int CW = AW - 1;
    localparam logic [1:0] R_CTRL  = 2'd0;
    localparam logic [1:0] R_COUNT = 2'd1;
    localparam logic [1:0] R_CMP   = 2'd2;
    localparam logic [1:0] R_STAT  = 2'd3;

    logic [CW-1:0]       chan;
    logic [1:0]          ridx;
    logic [WIDTH-1:0]    ctrl_rd  [CHANNELS];
    logic [WIDTH-1:0]    count_rd [CHANNELS];
    logic [WIDTH-1:0]    cmp_rd   [CHANNELS];
    logic [WIDTH-1:0]    stat_rd  [CHANNELS];
    logic [CHANNELS-1:0] irq_nx;
    logic [WIDTH-1:0]    rd_nx;

    // One spare channel bit keeps out-of-range channels from aliasing onto real ones.
    assign chan = CW'(addr >> 2);
    assign ridx = addr[1:0];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic             sel, we_ctrl, we_count, we_cmp, we_stat, tick, hit, step;
        logic             en_q, en_d, oneshot_q, clr_q, irqen_q, match_q, match_d, ovf_q, ovf_d;
        logic [7:0]       psc_q, pcnt_q, pcnt_d;
        logic [WIDTH-1:0] count_q, count_d, cmp_q;

        assign sel      = wr_en && (chan == CW'(g));
        assign we_ctrl  = sel && (ridx == R_CTRL);
        assign we_count = sel && (ridx == R_COUNT);
        assign we_cmp   = sel && (ridx == R_CMP);
        assign we_stat  = sel && (ridx == R_STAT);
        assign tick     = en_q && (pcnt_q == psc_q);
        assign hit      = (count_q == cmp_q);
        // Oneshot freezes COUNT on a match and clr_on_match reloads zero; otherwise keep counting.
        assign step     = !hit || (!oneshot_q && !clr_q);

        always_comb begin
            en_d    = en_q;
            pcnt_d  = '0;
            count_d = count_q;
            match_d = match_q;
            ovf_d   = ovf_q;
            if (we_stat) begin
                match_d = match_q & ~wr_data[0];
                ovf_d   = ovf_q & ~wr_data[1];
            end
            if (en_q && !tick)
                pcnt_d = pcnt_q + 8'd1;
            if (we_count) begin
                count_d = wr_data;
            end else if (tick) begin
                if (hit) begin
                    match_d = 1'b1;
                    if (oneshot_q)
                        en_d = 1'b0;
                    else if (clr_q)
                        count_d = '0;
                end
                if (step) begin
                    count_d = count_q + WIDTH'(1);
                    if (&count_q)
                        ovf_d = 1'b1;
                end
            end
            if (we_ctrl) begin
                en_d   = wr_data[0];
                pcnt_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                en_q      <= 1'b0;
                oneshot_q <= 1'b0;
                clr_q     <= 1'b0;
                psc_q     <= '0;
                pcnt_q    <= '0;
                count_q   <= '0;
                cmp_q     <= '0;
                match_q   <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                en_q    <= en_d;
                pcnt_q  <= pcnt_d;
                count_q <= count_d;
                match_q <= match_d;
                ovf_q   <= ovf_d;
                if (we_ctrl) begin
                    oneshot_q <= wr_data[1];
                    clr_q     <= wr_data[2];
                    psc_q     <= wr_data[15:8];
                end
                if (we_cmp)
                    cmp_q <= wr_data;
            end
        end

`ifdef TIMER_COUNTER_BANK_IRQ_EN
        logic irqen_d;
        assign irqen_d = we_ctrl ? wr_data[3] : irqen_q;
        always_ff @(posedge clk) begin
            if (!reset)
                irqen_q <= 1'b0;
            else
                irqen_q <= irqen_d;
        end
        // Built from next-state flags so irq rises on the same edge that sets match.
        assign irq_nx[g] = match_d & irqen_d;
`else
        assign irqen_q   = 1'b0;
        assign irq_nx[g] = 1'b0;
`endif

        assign ctrl_rd[g]  = WIDTH'({psc_q, 4'b0000, irqen_q, clr_q, oneshot_q, en_q});
        assign count_rd[g] = count_q;
        assign cmp_rd[g]   = cmp_q;
        assign stat_rd[g]  = WIDTH'({ovf_q, match_q});
    end

    always_comb begin
        rd_nx = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (chan == CW'(i)) begin
                case (ridx)
                    R_CTRL:  rd_nx = ctrl_rd[i];
                    R_COUNT: rd_nx = count_rd[i];
                    R_CMP:   rd_nx = cmp_rd[i];
                    default: rd_nx = stat_rd[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
            irq     <= '0;
        end else begin
            rd_data <= rd_nx;
            irq     <= irq_nx;
        end
    end
endmodule
